// File: rtl/and_gate_pkg.sv
// Shared defaults for the structural AND gate block.
`timescale 1ns / 1ps

package and_gate_pkg;

  localparam int AND_WIDTH_DEFAULT = 1;
  localparam int AND_CNT_W_DEFAULT = 8;

endpackage : and_gate_pkg

// File: rtl/and2_cell.sv
// Single 2-input AND built from exactly one gate primitive.
`timescale 1ns / 1ps

module and2_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  and g_and (y, a, b);

endmodule : and2_cell

// File: rtl/and_gate_structural.sv
// Structural multi-lane AND: the y / y_all path uses only and2_cell instances,
// plus a registered copy of y and a saturating rise counter on lane 0.
`timescale 1ns / 1ps

module and_gate_structural
  import and_gate_pkg::*;
#(
  parameter int WIDTH = AND_WIDTH_DEFAULT,
  parameter int CNT_W = AND_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             y_all,
  output logic [WIDTH-1:0] y_q,
  output logic [CNT_W-1:0] rise_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // chain[i] holds the AND of y[i:0]; its top bit is the full reduction.
  logic [WIDTH-1:0] chain;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    and2_cell u_lane (
      .a (a[i]),
      .b (b[i]),
      .y (y[i])
    );
  end

  assign chain[0] = y[0];

  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    and2_cell u_chain (
      .a (chain[i-1]),
      .b (y[i]),
      .y (chain[i])
    );
  end

  assign y_all = chain[WIDTH-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of y_q and rise_cnt, not ones updated mid-block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q      <= '0;
      rise_cnt <= '0;
    end else begin
      y_q <= y;
      if (!y_q[0] && y[0] && (rise_cnt != CNT_MAX)) begin
        rise_cnt <= rise_cnt + CNT_W'(1);
      end
    end
  end

endmodule : and_gate_structural

// File: tb/tb_and_gate_structural.sv
// Scoreboard bench: the driver pushes expected outputs from a spec-level model,
// an independent monitor pops and compares one cycle-phase later.
`timescale 1ns / 1ps

module tb_and_gate_structural;

  localparam int W      = 4;
  localparam int CW     = 3;
  localparam int CMAX   = (1 << CW) - 1;
  localparam int N_RAND = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  a   = '0;
  logic [W-1:0]  b   = '0;
  logic [W-1:0]  y;
  logic          y_all;
  logic [W-1:0]  y_q;
  logic [CW-1:0] rise_cnt;

  and_gate_structural #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .y        (y),
    .y_all    (y_all),
    .y_q      (y_q),
    .rise_cnt (rise_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    logic         y_all;
    logic [W-1:0] y_q;
    int           cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model state: value the register holds now, and how many rises it has seen.
  logic [W-1:0] m_q   = '0;
  int           m_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // One stimulus step: applied between edges, so a reset here is asynchronous.
  task automatic drive(input logic r, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t         e;
    logic [W-1:0] prod;
    @(negedge clk);
    rst  = r;
    a    = av;
    b    = bv;
    prod = av & bv;
    if (r) begin
      m_q   = '0;
      m_cnt = 0;
    end
    e.y     = prod;
    e.y_all = (prod == {W{1'b1}});
    e.y_q   = m_q;
    e.cnt   = m_cnt;
    sb.push_back(e);
    if (!r) begin
      if (m_q[0] == 1'b0 && prod[0] == 1'b1) m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      m_q = prod;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("y",        32'(y),        32'(e.y));
        check("y_all",    32'(y_all),    32'(e.y_all));
        check("y_q",      32'(y_q),      32'(e.y_q));
        check("rise_cnt", 32'(rise_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : driver
    logic [W-1:0] ra, rb;
    logic         rr;
    // Reset held for a couple of cycles, truth table on lane 0 under reset.
    drive(1'b1, 4'b0000, 4'b0000);
    drive(1'b1, 4'b0000, 4'b0001);
    drive(1'b1, 4'b0001, 4'b0000);
    drive(1'b1, 4'b0001, 4'b0001);
    // Registered path: hold 1&1, then drop a.
    drive(1'b0, 4'b0001, 4'b0001);
    drive(1'b0, 4'b0001, 4'b0001);
    drive(1'b0, 4'b0000, 4'b0001);
    drive(1'b0, 4'b0000, 4'b0001);
    // Multi-lane patterns.
    drive(1'b0, 4'b1011, 4'b1110);
    drive(1'b0, 4'b1111, 4'b1111);
    // Reach five rises, then reset between edges while y_q[0] is 1.
    drive(1'b1, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'b1111, 4'b0000);
      drive(1'b0, 4'b1111, 4'b1111);
    end
    drive(1'b0, 4'b1111, 4'b1111);
    drive(1'b1, 4'b1111, 4'b1111);
    // y[0]=1 at the first edge after reset counts as a rise.
    drive(1'b0, 4'b1111, 4'b1111);
    drive(1'b0, 4'b1111, 4'b1111);
    // Saturation: toggle b with a=1 for ten rises.
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 4'b0001, 4'b0000);
      drive(1'b0, 4'b0001, 4'b0001);
    end
    drive(1'b0, 4'b0001, 4'b0000);
    // Randomized traffic with occasional resets.
    for (int k = 0; k < N_RAND; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rr = ($urandom_range(0, 31) == 0);
      drive(rr, ra, rb);
    end
    @(negedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_and_gate_structural
